// File: rtl/ascon128a_pkg.sv
// Shared constants and types for the Ascon-128a stream loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ascon128a_pkg;

   localparam int WORDS_PER_FIELD = 4;
   localparam int FIELD_W         = WORDS_PER_FIELD * 32;
   localparam int FRAME_WORDS     = 16;
   localparam int OUT_WORDS       = 8;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_START  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UNLOAD = 2'd3
   } state_t;

   // Field order matches the word order on the input stream: the key
   // occupies the most significant bits, so stream word 0 lands in bits
   // [511:480].
   typedef struct packed {
      logic [FIELD_W-1:0] sk;
      logic [FIELD_W-1:0] n;
      logic [FIELD_W-1:0] a;
      logic [FIELD_W-1:0] p;
   } frame_t;

endpackage

// File: rtl/ascon128a_word_loader.sv
// Purpose: assembles a 16-word key/nonce/AD/plaintext frame for the Ascon-128a
//          core, strobes it, waits CORE_LAT cycles, then streams out C and T as 8 words.
// Latency: word 15 accepted -> first out_valid after CORE_LAT+1 cycles; backpressure:
//          in_ready low from START until the last output word transfers; out_data held while stalled.
//
// Ports:
//   CLK, RST          clock, async active-low reset
//   in_data/valid/ready   32-bit input word stream
//   out_data/valid/ready  32-bit output word stream (C[127:96] first, T[31:0] last)
//   core_sk/n/a/p     assembled frame held on the core inputs
//   core_start        one-cycle strobe once the frame is complete
//   core_c/core_t     core results, sampled when the latency counter expires
//   busy              high except when idle in LOAD at word index 0
module ascon128a_word_loader
   import ascon128a_pkg::*;
#(
   parameter int CORE_LAT = 45,
   parameter int WORD_W   = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      core_sk,
   output logic [127:0]      core_n,
   output logic [127:0]      core_a,
   output logic [127:0]      core_p,
   output logic              core_start,
   input  logic [127:0]      core_c,
   input  logic [127:0]      core_t,
   output logic              busy
);

   state_t       state_q;
   state_t       state_d;
   logic [3:0]   in_idx_q;
   logic [7:0]   lat_cnt_q;
   logic [2:0]   out_idx_q;
   frame_t       frame_q;
   logic [255:0] ct_q;
   // Keeps in_ready low while reset is asserted and for the first edge
   // after release, so a word is never taken during reset.
   logic         rdy_en_q;

   logic         in_acc;
   logic         out_acc;

   assign in_acc  = in_valid & in_ready;
   assign out_acc = out_valid & out_ready;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: begin
            if (in_acc && (in_idx_q == 4'(FRAME_WORDS - 1))) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_cnt_q == 8'd0) begin
               state_d = ST_UNLOAD;
            end
         end
         ST_UNLOAD: begin
            if (out_acc && (out_idx_q == 3'(OUT_WORDS - 1))) begin
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      core_start = 1'b0;
      out_data   = '0;
      busy       = !((state_q == ST_LOAD) && (in_idx_q == 4'd0));
      case (state_q)
         ST_LOAD:   in_ready = rdy_en_q;
         ST_START:  core_start = 1'b1;
         ST_UNLOAD: begin
            out_valid = 1'b1;
            // Index 0 selects bits [255:224] (C[127:96]); index 7 selects T[31:0].
            out_data  = ct_q[{~out_idx_q, 5'd0} +: WORD_W];
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: frame slots, latency counter, result capture, out index
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdy_en_q  <= 1'b0;
         in_idx_q  <= 4'd0;
         lat_cnt_q <= 8'd0;
         out_idx_q <= 3'd0;
         frame_q   <= '0;
         ct_q      <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         case (state_q)
            ST_LOAD: begin
               if (in_acc) begin
                  // Word i goes to bits [511-32i -: 32]; ~idx gives 15-i.
                  frame_q[{~in_idx_q, 5'd0} +: WORD_W] <= in_data;
                  in_idx_q <= in_idx_q + 4'd1;  // wraps to 0 after word 15
               end
            end
            ST_START: begin
               lat_cnt_q <= 8'(CORE_LAT - 1);
            end
            ST_WAIT: begin
               if (lat_cnt_q == 8'd0) begin
                  ct_q      <= {core_c, core_t};
                  out_idx_q <= 3'd0;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 8'd1;
               end
            end
            ST_UNLOAD: begin
               if (out_acc) begin
                  out_idx_q <= out_idx_q + 3'd1;  // wraps to 0 after word 7
               end
            end
            default: ;
         endcase
      end
   end

   assign core_sk = frame_q.sk;
   assign core_n  = frame_q.n;
   assign core_a  = frame_q.a;
   assign core_p  = frame_q.p;

endmodule

// File: tb/tb_ascon128a_word_loader.sv
// Bench for ascon128a_word_loader: three instances (CORE_LAT 4, 1, 255), each
// with a stub core C = P ^ SK, T = N ^ A. Expected output words are queued
// when a frame is driven and popped when the outputs are compared.
module tb_ascon128a_word_loader;

   logic         CLK = 1'b0;
   logic         RST;
   logic [31:0]  in_data    [3];
   logic         in_valid   [3];
   logic         in_ready   [3];
   logic [31:0]  out_data   [3];
   logic         out_valid  [3];
   logic         out_ready  [3];
   logic [127:0] core_sk    [3];
   logic [127:0] core_n     [3];
   logic [127:0] core_a     [3];
   logic [127:0] core_p     [3];
   logic         core_start [3];
   logic [127:0] core_c     [3];
   logic [127:0] core_t     [3];
   logic         busy       [3];

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ascon128a_word_loader #(
         .CORE_LAT ((g == 0) ? 4 : ((g == 1) ? 1 : 255)),
         .WORD_W   (32)
      ) u_dut (
         .CLK        (CLK),
         .RST        (RST),
         .in_data    (in_data[g]),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .out_data   (out_data[g]),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .core_sk    (core_sk[g]),
         .core_n     (core_n[g]),
         .core_a     (core_a[g]),
         .core_p     (core_p[g]),
         .core_start (core_start[g]),
         .core_c     (core_c[g]),
         .core_t     (core_t[g]),
         .busy       (busy[g])
      );
      assign core_c[g] = core_p[g] ^ core_sk[g];
      assign core_t[g] = core_n[g] ^ core_a[g];
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];

   int          acc15;
   bit          s_timeout;
   logic [31:0] d_got [8];
   logic [31:0] d_held;
   int          d_n, d_first_vld, d_start_cyc, d_start_cnt;
   bit          d_inrdy_bad, d_hold_bad, d_busy_bad, d_timeout;

   // Drives one 16-word frame into instance g and queues the 8 expected
   // output words. Entered and left just after a rising edge.
   task automatic send_frame(input int g, input logic [31:0] w[16], input bit throttle);
      int i = 0;
      int guard = 0;
      bit tog = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(w[12+k] ^ w[k]);
      for (int k = 0; k < 4; k++) exp_q.push_back(w[4+k] ^ w[8+k]);
      acc15 = -1;
      s_timeout = 1'b0;
      while (i < 16 && guard < 500) begin
         in_data[g]  = w[i];
         in_valid[g] = throttle ? tog : 1'b1;
         tog = ~tog;
         @(negedge CLK);
         if (in_valid[g] && in_ready[g]) begin
            if (i == 15) acc15 = cyc + 1;
            i++;
         end
         @(posedge CLK); #1;
         guard++;
      end
      in_valid[g] = 1'b0;
      if (i < 16) s_timeout = 1'b1;
   endtask

   // Collects the 8 output words of instance g, recording timing and
   // handshake observations for the calling test to compare.
   task automatic drain(input int g, input bit rand_ready, input int stall_at,
                        input int stall_len, input bit junk_in);
      int guard = 0;
      int stalled = 0;
      bit held_set = 1'b0;
      d_n = 0; d_first_vld = -1; d_start_cyc = -1; d_start_cnt = 0;
      d_inrdy_bad = 0; d_hold_bad = 0; d_busy_bad = 0; d_timeout = 0;
      while (d_n < 8 && guard < 1000) begin
         if (stall_len > 0 && d_n == stall_at && stalled < stall_len)
            out_ready[g] = 1'b0;
         else
            out_ready[g] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid[g] = junk_in;
         in_data[g]  = $urandom;
         @(negedge CLK);
         if (core_start[g]) begin
            d_start_cnt++;
            d_start_cyc = cyc;
         end
         if (in_ready[g]) d_inrdy_bad = 1'b1;
         if (!busy[g]) d_busy_bad = 1'b1;
         if (out_valid[g] && d_first_vld < 0) d_first_vld = cyc;
         if (out_valid[g] && !out_ready[g] && stall_len > 0 && d_n == stall_at) begin
            if (held_set && out_data[g] !== d_held) d_hold_bad = 1'b1;
            d_held = out_data[g];
            held_set = 1'b1;
            stalled++;
         end
         if (out_valid[g] && out_ready[g]) begin
            d_got[d_n] = out_data[g];
            d_n++;
         end
         @(posedge CLK); #1;
         guard++;
      end
      out_ready[g] = 1'b0;
      in_valid[g]  = 1'b0;
      if (d_n < 8) d_timeout = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] w[16];
      int guard = 0;
      int xfers = 0;
      bit late_vld = 1'b0;
      // Power-on reset
      RST = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_checks++;
      if ({out_valid[0], core_start[0], busy[0]} !== 3'b000 || out_data[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_ctrl: valid/start/busy=%b out_data=%h required 000/0",
                  {out_valid[0], core_start[0], busy[0]}, out_data[0]);
      end
      n_checks++;
      if ((core_sk[0] | core_n[0] | core_a[0] | core_p[0]) !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_core: core fields not zero sk=%h required 0", core_sk[0]);
      end
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      n_checks++;
      if (in_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready[0]);
      end
      @(posedge CLK); #1;

      // Reset in the middle of the unload
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      send_frame(0, w, 1'b0);
      out_ready[0] = 1'b1;
      while (xfers < 2 && guard < 100) begin
         @(negedge CLK);
         if (out_valid[0] && out_ready[0]) xfers++;
         @(posedge CLK); #1;
         guard++;
      end
      #2 RST = 1'b0;
      #1;
      n_checks++;
      if ({out_valid[0], core_start[0], busy[0], in_ready[0]} !== 4'b0000 ||
          out_data[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_ctrl: valid/start/busy/rdy=%b out_data=%h required 0000/0",
                  {out_valid[0], core_start[0], busy[0], in_ready[0]}, out_data[0]);
      end
      n_checks++;
      if ((core_sk[0] | core_n[0] | core_a[0] | core_p[0]) !== 128'h0) begin
         n_fail++;
         $display("FAIL midreset_core: core fields not zero sk=%h required 0", core_sk[0]);
      end
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b1;
      exp_q.delete();
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (out_valid[0]) late_vld = 1'b1;
      end
      n_checks++;
      if (late_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_no_valid: out_valid seen=%b required 0", late_vld);
      end
      n_checks++;
      if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_idle: in_ready=%b busy=%b required 1/0", in_ready[0], busy[0]);
      end
      out_ready[0] = 1'b0;
      @(posedge CLK); #1;
   endtask

   // Shared body of the spec-frame tests (plain and throttled input).
   task automatic test_spec_frame(input bit throttle, input string tag);
      logic [31:0] w[16];
      logic [31:0] e;
      for (int i = 0; i < 16; i++)
         w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      send_frame(0, w, throttle);
      drain(0, 1'b0, 0, 0, throttle);
      n_checks++;
      if (s_timeout || d_timeout || d_n !== 8) begin
         n_fail++;
         $display("FAIL %s_count: words=%0d timeouts=%b%b required 8/00", tag, d_n, s_timeout, d_timeout);
      end
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (d_got[k] !== e || e !== 32'h30303030) begin
            n_fail++;
            $display("FAIL %s_word%0d: got %h required %h", tag, k, d_got[k], e);
         end
      end
      n_checks++;
      if (d_start_cnt !== 1 || d_start_cyc !== acc15) begin
         n_fail++;
         $display("FAIL %s_start: pulses=%0d at %0d required 1 at %0d", tag, d_start_cnt, d_start_cyc, acc15);
      end
      n_checks++;
      if (d_first_vld - acc15 !== 5) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d required 5", tag, d_first_vld - acc15);
      end
      n_checks++;
      if (d_inrdy_bad || d_busy_bad) begin
         n_fail++;
         $display("FAIL %s_stall: in_ready_seen=%b busy_low_seen=%b required 0/0", tag, d_inrdy_bad, d_busy_bad);
      end
      n_checks++;
      if (core_sk[0] !== 128'h000102030405060708090a0b0c0d0e0f ||
          core_n[0]  !== 128'h101112131415161718191a1b1c1d1e1f) begin
         n_fail++;
         $display("FAIL %s_sk_n: sk=%h n=%h", tag, core_sk[0], core_n[0]);
      end
      n_checks++;
      if (core_a[0] !== 128'h202122232425262728292a2b2c2d2e2f ||
          core_p[0] !== 128'h303132333435363738393a3b3c3d3e3f) begin
         n_fail++;
         $display("FAIL %s_a_p: a=%h p=%h", tag, core_a[0], core_p[0]);
      end
      @(negedge CLK);
      n_checks++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_end: valid/busy/rdy=%b required 001", tag,
                  {out_valid[0], busy[0], in_ready[0]});
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_single_frame();
      test_spec_frame(1'b0, "single");
   endtask

   task automatic test_throttle();
      test_spec_frame(1'b1, "throttle");
   endtask

   task automatic test_backpressure();
      logic [31:0] w[16];
      logic [31:0] e;
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      send_frame(0, w, 1'b0);
      drain(0, 1'b0, 2, 10, 1'b0);
      n_checks++;
      if (d_timeout || d_n !== 8 || d_hold_bad) begin
         n_fail++;
         $display("FAIL bp_hold: words=%0d hold_changed=%b required 8/0", d_n, d_hold_bad);
      end
      for (int k = 0; k < 8; k++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (d_got[k] !== e) begin
            n_fail++;
            $display("FAIL bp_word%0d: got %h required %h", k, d_got[k], e);
         end
         if (k == 2) begin
            n_checks++;
            if (d_held !== e) begin
               n_fail++;
               $display("FAIL bp_held_c63_32: got %h required %h", d_held, e);
            end
         end
      end
      @(negedge CLK);
      n_checks++;
      if (out_valid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_no_dup: out_valid=%b required 0", out_valid[0]);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_latency();
      logic [31:0] w[16];
      logic [31:0] e;
      int lat;
      for (int g = 1; g < 3; g++) begin
         lat = (g == 1) ? 1 : 255;
         for (int i = 0; i < 16; i++) w[i] = $urandom;
         send_frame(g, w, 1'b0);
         drain(g, 1'b0, 0, 0, 1'b0);
         n_checks++;
         if (d_timeout || d_first_vld - acc15 !== lat + 1) begin
            n_fail++;
            $display("FAIL latency_%0d: got %0d required %0d", lat, d_first_vld - acc15, lat + 1);
         end
         for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (d_got[k] !== e) begin
               n_fail++;
               $display("FAIL latency_%0d_word%0d: got %h required %h", lat, k, d_got[k], e);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[16];
      logic [31:0] e;
      for (int f = 0; f < 20; f++) begin
         for (int i = 0; i < 16; i++) w[i] = $urandom;
         send_frame(0, w, 1'($urandom_range(0, 1)));
         drain(0, 1'b1, 0, 0, 1'b1);
         n_checks++;
         if (s_timeout || d_timeout || d_n !== 8 || d_inrdy_bad) begin
            n_fail++;
            $display("FAIL b2b_frame%0d: words=%0d in_ready_seen=%b required 8/0", f, d_n, d_inrdy_bad);
         end
         for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (d_got[k] !== e) begin
               n_fail++;
               $display("FAIL b2b_frame%0d_word%0d: got %h required %h", f, k, d_got[k], e);
            end
         end
      end
   endtask

   initial begin
      RST = 1'b0;
      for (int g = 0; g < 3; g++) begin
         in_data[g]   = 32'h0;
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b0;
      end
      test_reset();
      test_single_frame();
      test_throttle();
      test_backpressure();
      test_latency();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d required completion", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
